// File: rtl/cop0_exc_entry_pkg.sv
// Shared COP0 exception-entry constants: cause codes, vector geometry and the capture record.
package cop0_exc_entry_pkg;

  localparam logic [4:0] CPU_EXC_CAUSE_DEC  = 5'd1;
  localparam logic [4:0] CPU_EXC_CAUSE_BUS  = 5'd2;
  localparam logic [4:0] CPU_EXC_CAUSE_SYS  = 5'd3;
  localparam logic [4:0] CPU_EXC_CAUSE_BRK  = 5'd4;
  localparam logic [4:0] CPU_EXC_CAUSE_IRQ0 = 5'd8;

  localparam int CPU_EXC_VEC_SHIFT = 5;
  localparam int CPU_EXC_IVT_W     = 22;

  typedef struct packed {
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [31:0] vec;
  } exc_rec_t;

  // Each cause owns a 32-byte slot above the 1 KiB-aligned IVT base.
  function automatic logic [31:0] exc_vector(input logic [CPU_EXC_IVT_W-1:0] ivt,
                                             input logic [4:0] cause);
    return {ivt, 10'b0} + (32'(cause) << CPU_EXC_VEC_SHIFT);
  endfunction

endpackage

// File: rtl/cop0_irq_sync.sv
// Parameterised-width 2-flop synchronizer with synchronous active-high reset to 0.
module cop0_irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cop0_exc_entry.sv
// Exception-entry sequencer: capture -> drain -> commit EPC/IE -> redirect to IVT (valid/ack).
// Define CPU_EXC_IRQ_SYNC_EN to pass i_irq through a 2-flop synchronizer (+2 cycles IRQ latency).
module cop0_exc_entry
  import cop0_exc_entry_pkg::*;
#(
  parameter int IRQ_NUM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_core_stall,
  input  logic [IRQ_NUM-1:0]       i_irq,
  input  logic                     i_sr_ie,
  input  logic [CPU_EXC_IVT_W-1:0] i_ivt,
  input  logic                     i_dec_err,
  input  logic                     i_bus_err,
  input  logic                     i_syscall,
  input  logic                     i_break,
  input  logic [31:0]              i_exc_pc,
  input  logic [31:0]              i_irq_pc,
  input  logic                     i_rfe_wb,
  output logic                     o_flush,
  output logic                     o_epc_we,
  output logic [31:0]              o_epc_val,
  output logic                     o_ie_save,
  output logic [4:0]               o_cause,
  output logic                     o_redir_valid,
  output logic [31:0]              o_redir_addr,
  input  logic                     i_redir_ack,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT
  } state_t;

  state_t   state_q, state_d;
  exc_rec_t rec_q, rec_d;

  logic [IRQ_NUM-1:0] irq_s;
  logic [IRQ_NUM-1:0] irq_m;

`ifdef CPU_EXC_IRQ_SYNC_EN
  cop0_irq_sync #(
    .WIDTH (IRQ_NUM)
  ) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_irq),
    .q_o (irq_s)
  );
`else
  assign irq_s = i_irq;
`endif

  assign irq_m = irq_s & {IRQ_NUM{i_sr_ie}};

  // Event selection, highest priority wins; lower-priority sync pulses are dropped.
  logic        evt_vld;
  logic [4:0]  evt_cause;
  logic [31:0] evt_epc;

  always_comb begin
    evt_vld   = 1'b0;
    evt_cause = 5'd0;
    evt_epc   = 32'd0;
    if (i_bus_err) begin
      evt_vld   = 1'b1;
      evt_cause = CPU_EXC_CAUSE_BUS;
      evt_epc   = i_exc_pc;
    end else if (i_dec_err) begin
      evt_vld   = 1'b1;
      evt_cause = CPU_EXC_CAUSE_DEC;
      evt_epc   = i_exc_pc;
    end else if (i_syscall) begin
      evt_vld   = 1'b1;
      evt_cause = CPU_EXC_CAUSE_SYS;
      evt_epc   = i_exc_pc;
    end else if (i_break) begin
      evt_vld   = 1'b1;
      evt_cause = CPU_EXC_CAUSE_BRK;
      evt_epc   = i_exc_pc;
    end else begin
      // Scan downwards so the lowest-numbered pending line ends up selected.
      for (int k = IRQ_NUM - 1; k >= 0; k--) begin
        if (irq_m[k]) begin
          evt_vld   = 1'b1;
          evt_cause = CPU_EXC_CAUSE_IRQ0 + 5'(k);
          evt_epc   = i_irq_pc;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rec_d         = rec_q;
    o_flush       = 1'b0;
    o_epc_we      = 1'b0;
    o_ie_save     = 1'b0;
    o_redir_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evt_vld) begin
          state_d   = ST_DRAIN;
          rec_d.cause = evt_cause;
          rec_d.epc   = evt_epc;
          rec_d.vec   = exc_vector(i_ivt, evt_cause);
        end
      end
      ST_DRAIN: begin
        // An RFE retiring now owns the COP0 write port; defer commit by a cycle.
        if (!i_core_stall && !i_rfe_wb) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        o_flush   = 1'b1;
        o_epc_we  = 1'b1;
        o_ie_save = 1'b1;
        state_d   = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        o_flush       = 1'b1;
        o_redir_valid = 1'b1;
        if (i_redir_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
    end
  end

  assign o_epc_val    = rec_q.epc;
  assign o_cause      = rec_q.cause;
  assign o_redir_addr = rec_q.vec;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cop0_exc_entry.sv
// Directed bench for cop0_exc_entry: hand-computed timing, vectors, priority, stall/RFE and reset abort.
module tb_cop0_exc_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_core_stall;
  logic [7:0]  i_irq;
  logic        i_sr_ie;
  logic [21:0] i_ivt;
  logic        i_dec_err, i_bus_err, i_syscall, i_break;
  logic [31:0] i_exc_pc, i_irq_pc;
  logic        i_rfe_wb;
  logic        o_flush, o_epc_we, o_ie_save, o_redir_valid, o_busy;
  logic [31:0] o_epc_val, o_redir_addr;
  logic [4:0]  o_cause;
  logic        i_redir_ack;

  int checks   = 0;
  int failures = 0;

  cop0_exc_entry #(.IRQ_NUM(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_core_stall  (i_core_stall),
    .i_irq         (i_irq),
    .i_sr_ie       (i_sr_ie),
    .i_ivt         (i_ivt),
    .i_dec_err     (i_dec_err),
    .i_bus_err     (i_bus_err),
    .i_syscall     (i_syscall),
    .i_break       (i_break),
    .i_exc_pc      (i_exc_pc),
    .i_irq_pc      (i_irq_pc),
    .i_rfe_wb      (i_rfe_wb),
    .o_flush       (o_flush),
    .o_epc_we      (o_epc_we),
    .o_epc_val     (o_epc_val),
    .o_ie_save     (o_ie_save),
    .o_cause       (o_cause),
    .o_redir_valid (o_redir_valid),
    .o_redir_addr  (o_redir_addr),
    .i_redir_ack   (i_redir_ack),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_core_stall = 0; i_irq = '0; i_sr_ie = 0; i_ivt = '0;
    i_dec_err = 0; i_bus_err = 0; i_syscall = 0; i_break = 0;
    i_exc_pc = '0; i_irq_pc = '0; i_rfe_wb = 0; i_redir_ack = 0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({o_flush, o_epc_we, o_epc_val, o_ie_save, o_cause, o_redir_valid, o_redir_addr, o_busy} !== 74'd0) begin
      failures++;
      $display("FAIL reset_outputs: flush=%b we=%b epc=%h ie=%b cause=%0d v=%b addr=%h busy=%b, all required 0",
               o_flush, o_epc_we, o_epc_val, o_ie_save, o_cause, o_redir_valid, o_redir_addr, o_busy);
    end
    // Ack while valid is low must not start anything.
    i_redir_ack = 1'b1;
    tick();
    i_redir_ack = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL idle_ack_ignored: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_syscall();
    i_syscall = 1; i_exc_pc = 32'h0000_1000; i_ivt = 22'h000001;
    tick();  // N+1: DRAIN
    i_syscall = 0;
    checks++;
    if ({o_busy, o_epc_we, o_flush} !== 3'b100) begin
      failures++; $display("FAIL sys_drain: busy/we/flush=%b required 100", {o_busy, o_epc_we, o_flush});
    end
    i_redir_ack = 1;  // held early: ignored until valid rises
    tick();  // N+2: COMMIT
    checks++;
    if ({o_flush, o_epc_we, o_ie_save, o_redir_valid} !== 4'b1110 || o_epc_val !== 32'h1000 || o_cause !== 5'd3) begin
      failures++; $display("FAIL sys_commit: f/we/ie/v=%b epc=%h cause=%0d required 1110 00001000 3",
                           {o_flush, o_epc_we, o_ie_save, o_redir_valid}, o_epc_val, o_cause);
    end
    tick();  // N+3: REDIRECT
    checks++;
    if (o_redir_valid !== 1'b1 || o_redir_addr !== 32'h0000_0460 || o_flush !== 1'b1 || o_epc_we !== 1'b0) begin
      failures++; $display("FAIL sys_redirect: v=%b addr=%h flush=%b we=%b required 1 00000460 1 0",
                           o_redir_valid, o_redir_addr, o_flush, o_epc_we);
    end
    tick();  // N+4: IDLE
    i_redir_ack = 0;
    checks++;
    if ({o_busy, o_redir_valid, o_flush} !== 3'b000) begin
      failures++; $display("FAIL sys_idle: busy/v/flush=%b required 000", {o_busy, o_redir_valid, o_flush});
    end
  endtask

  task automatic test_irq_mask();
    int act;
    act = 0;
    i_irq = 8'b0000_0100; i_sr_ie = 0; i_irq_pc = 32'h0000_2000; i_exc_pc = 32'hDEAD_0000; i_ivt = 22'h000002;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_busy || o_epc_we || o_flush) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++; $display("FAIL irq_masked: active_cycles=%0d required 0", act);
    end
    i_sr_ie = 1;
    tick();  // DRAIN
    i_sr_ie = 0;  // COP0 clears IE on commit; level IRQ stays high
    tick();  // COMMIT
    checks++;
    if (o_cause !== 5'd10 || o_epc_val !== 32'h0000_2000 || o_ie_save !== 1'b1) begin
      failures++; $display("FAIL irq_commit: cause=%0d epc=%h ie=%b required 10 00002000 1", o_cause, o_epc_val, o_ie_save);
    end
    i_redir_ack = 1;
    tick();  // REDIRECT
    checks++;
    if (o_redir_valid !== 1'b1 || o_redir_addr !== 32'h0000_0940) begin
      failures++; $display("FAIL irq_vector: v=%b addr=%h required 1 00000940", o_redir_valid, o_redir_addr);
    end
    tick();  // IDLE
    i_redir_ack = 0;
    tick();  // IRQ still high but masked
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL irq_remask: busy=%b required 0", o_busy);
    end
    i_irq = '0;
  endtask

  task automatic test_priority();
    i_bus_err = 1; i_dec_err = 1; i_irq = 8'b0000_0001; i_sr_ie = 1;
    i_exc_pc = 32'h0000_3000; i_irq_pc = 32'h0000_7777; i_ivt = 22'h3FFFFF;
    tick();  // DRAIN
    i_bus_err = 0; i_dec_err = 0; i_irq = '0; i_sr_ie = 0;
    i_ivt = 22'h000000;  // late change must not move the vector
    tick();  // COMMIT
    checks++;
    if (o_cause !== 5'd2 || o_epc_val !== 32'h0000_3000) begin
      failures++; $display("FAIL prio_cause: cause=%0d epc=%h required 2 00003000", o_cause, o_epc_val);
    end
    i_redir_ack = 1;
    tick();  // REDIRECT
    checks++;
    if (o_redir_addr !== 32'hFFFF_FC40) begin
      failures++; $display("FAIL prio_vector: addr=%h required FFFFFC40", o_redir_addr);
    end
    tick();  // IDLE
    i_redir_ack = 0;
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL prio_lost: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_stall_rfe();
    int we_cnt;
    int bad;
    we_cnt = 0; bad = 0;
    i_break = 1; i_core_stall = 1; i_exc_pc = 32'h0000_4000; i_ivt = 22'h000001;
    tick();  // DRAIN
    i_break = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_epc_we) we_cnt++;
      if (!o_busy || o_flush) bad++;
      tick();
    end
    i_core_stall = 0; i_rfe_wb = 1;
    if (o_epc_we) we_cnt++;
    tick();  // still DRAIN: RFE wins
    i_rfe_wb = 0;
    checks++;
    if (o_busy !== 1'b1 || o_epc_we !== 1'b0 || bad !== 0) begin
      failures++; $display("FAIL stall_hold: busy=%b we=%b bad=%0d required 1 0 0", o_busy, o_epc_we, bad);
    end
    tick();  // COMMIT
    if (o_epc_we) we_cnt++;
    checks++;
    if (o_epc_we !== 1'b1 || o_cause !== 5'd4 || o_epc_val !== 32'h0000_4000) begin
      failures++; $display("FAIL stall_commit: we=%b cause=%0d epc=%h required 1 4 00004000", o_epc_we, o_cause, o_epc_val);
    end
    tick();  // REDIRECT
    if (o_epc_we) we_cnt++;
    checks++;
    if (o_redir_addr !== 32'h0000_0480 || we_cnt !== 1) begin
      failures++; $display("FAIL stall_once: addr=%h epc_writes=%0d required 00000480 1", o_redir_addr, we_cnt);
    end
    i_redir_ack = 1;
    tick();
    i_redir_ack = 0;
  endtask

  task automatic test_hold_and_reset();
    int moved;
    moved = 0;
    i_dec_err = 1; i_exc_pc = 32'h0000_5000; i_ivt = 22'h000001;
    tick();  // DRAIN
    i_dec_err = 0;
    tick();  // COMMIT
    tick();  // REDIRECT
    for (int i = 0; i < 3; i++) begin
      if (o_redir_valid !== 1'b1 || o_redir_addr !== 32'h0000_0420) moved++;
      i_ivt = 22'h155555; i_syscall = 1;
      tick();
    end
    i_syscall = 0;
    checks++;
    if (moved !== 0 || o_redir_valid !== 1'b1 || o_redir_addr !== 32'h0000_0420 || o_cause !== 5'd1) begin
      failures++; $display("FAIL hold_stable: moved=%0d v=%b addr=%h cause=%0d required 0 1 00000420 1",
                           moved, o_redir_valid, o_redir_addr, o_cause);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({o_flush, o_epc_we, o_epc_val, o_ie_save, o_cause, o_redir_valid, o_redir_addr, o_busy} !== 74'd0) begin
      failures++; $display("FAIL mid_reset: flush=%b we=%b epc=%h ie=%b cause=%0d v=%b addr=%h busy=%b, all required 0",
                           o_flush, o_epc_we, o_epc_val, o_ie_save, o_cause, o_redir_valid, o_redir_addr, o_busy);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_redir_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: busy=%b v=%b required 0 0", o_busy, o_redir_valid);
    end
  endtask

  task automatic test_back_to_back();
    // New event presented in the very cycle the FSM returns to IDLE.
    i_syscall = 1; i_exc_pc = 32'h0000_6000; i_ivt = 22'h000000;
    tick(); i_syscall = 0;
    tick(); tick();
    i_redir_ack = 1;
    tick();  // IDLE
    i_redir_ack = 0;
    i_break = 1; i_exc_pc = 32'h0000_6004;
    tick();  // DRAIN
    i_break = 0;
    tick();  // COMMIT
    checks++;
    if (o_epc_we !== 1'b1 || o_cause !== 5'd4 || o_epc_val !== 32'h0000_6004) begin
      failures++; $display("FAIL b2b_commit: we=%b cause=%0d epc=%h required 1 4 00006004", o_epc_we, o_cause, o_epc_val);
    end
    tick();  // REDIRECT
    checks++;
    if (o_redir_addr !== 32'h0000_0080) begin
      failures++; $display("FAIL b2b_vector: addr=%h required 00000080", o_redir_addr);
    end
    i_redir_ack = 1;
    tick();
    i_redir_ack = 0;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_irq_mask();
    test_priority();
    test_stall_rfe();
    test_hold_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
